uart_cmd_rx: RTL

UART 8N1 receiver on i_uart_rx that turns single ASCII command bytes into one-cycle pulses. The pulses have the same shape as the debouncer's button outputs, so a host PC can drive the metronome (BPM ±1/±5, reset) in parallel with the probe buttons. Runs in the PLL clock domain. Its outputs are OR-ed with the debouncer outputs at top level.

---
 rtl/uart_cmd_rx_pkg.sv | 49 ++++
 rtl/uart_cmd_rx_if.sv | 22 ++
 rtl/uart_cmd_rx_baud_tick.sv | 36 +++
 rtl/uart_cmd_rx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_rx_pkg.sv
// Shared constants, FSM encoding and command decode for the metronome UART
// command receiver (and the planned BPM transmitter).
package metronome_uart_pkg;

  // Sample ticks per bit; the receiver samples at tick MID_SAMPLE of a bit.
  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 7;
  localparam int LAST_SAMPLE = OVERSAMPLE - 1;

  // ASCII command bytes accepted from the host PC.
  localparam logic [7:0] CMD_PLUS_1  = 8'h2B;  // '+'
  localparam logic [7:0] CMD_PLUS_5  = 8'h3E;  // '>'
  localparam logic [7:0] CMD_MINUS_1 = 8'h2D;  // '-'
  localparam logic [7:0] CMD_MINUS_5 = 8'h3C;  // '<'
  localparam logic [7:0] CMD_RESET_U = 8'h52;  // 'R'
  localparam logic [7:0] CMD_RESET_L = 8'h72;  // 'r'

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // One flag per button-equivalent command; at most one set per byte.
  typedef struct packed {
    logic plus_1;
    logic plus_5;
    logic minus_1;
    logic minus_5;
    logic reset;
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [7:0] b);
    cmd_t c;
    c = '0;
    case (b)
      CMD_PLUS_1:                c.plus_1  = 1'b1;
      CMD_PLUS_5:                c.plus_5  = 1'b1;
      CMD_MINUS_1:               c.minus_1 = 1'b1;
      CMD_MINUS_5:               c.minus_5 = 1'b1;
      CMD_RESET_U, CMD_RESET_L:  c.reset   = 1'b1;
      default:                   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Receiver output bundle: received byte, strobes and button-style command
// pulses. The receiver drives it through the master modport.
interface uart_cmd_rx_if;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_frame_err;
  logic       o_btn_plus_1;
  logic       o_btn_plus_5;
  logic       o_btn_minus_1;
  logic       o_btn_minus_5;
  logic       o_btn_reset;

  modport master (
    output o_rx_data, o_rx_valid, o_frame_err,
    output o_btn_plus_1, o_btn_plus_5, o_btn_minus_1, o_btn_minus_5, o_btn_reset
  );

  modport slave (
    input o_rx_data, o_rx_valid, o_frame_err,
    input o_btn_plus_1, o_btn_plus_5, o_btn_minus_1, o_btn_minus_5, o_btn_reset
  );
endinterface

// File: rtl/uart_cmd_rx_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick_o on the wrap.
// clr_i restarts the count so sampling can be phase-aligned to a start edge.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: DIV must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap   = (cnt_q == CNT_W'(DIV - 1));
  assign tick_o = wrap;

  // Next count: wrap to zero at DIV-1 or on an explicit clear.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || wrap) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver turning single ASCII command bytes into one-cycle
// button-style pulses for the metronome.
module uart_cmd_rx
  import metronome_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_uart_rx,
  uart_cmd_rx_if.master rx_if
);

  localparam int DIV = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);

  logic       sync1_q, sync2_q;
  logic       rx_s;
  logic       tick;
  logic       clr_tick;

  rx_state_e  state_q, state_d;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  cmd_t       cmd_q, cmd_d;

  assign rx_s = sync2_q;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i  (i_clk),
    .rst_i  (i_reset),
    .clr_i  (clr_tick),
    .tick_o (tick)
  );

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM: start detection, mid-bit sampling, stop check and decode.
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    cmd_d    = '0;
    clr_tick = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d  = START;
          scnt_d   = '0;
          clr_tick = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          if (scnt_q == 4'(MID_SAMPLE)) begin
            scnt_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              bidx_d  = '0;
            end else begin
              state_d = IDLE;  // too short to be a start bit
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (scnt_q == 4'(LAST_SAMPLE)) begin
            scnt_d  = '0;
            shift_d = {rx_s, shift_q[7:1]};
            if (bidx_q == 3'd7) state_d = STOP;
            else                bidx_d  = bidx_q + 3'd1;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (scnt_q == 4'(LAST_SAMPLE)) begin
            scnt_d = '0;
            if (rx_s) begin
              valid_d = 1'b1;
              data_d  = shift_q;
              cmd_d   = decode_cmd(shift_q);
              state_d = IDLE;  // early return allows a back-to-back start bit
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end

      BREAK: begin
        if (rx_s) state_d = IDLE;  // wait out a held-low line
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; a reset drops any partial frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bidx_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bidx_q  <= bidx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      cmd_q   <= cmd_d;
    end
  end

  // Shift register holds only in-flight data, so it needs no reset.
  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
  end

  assign rx_if.o_rx_data     = data_q;
  assign rx_if.o_rx_valid    = valid_q;
  assign rx_if.o_frame_err   = ferr_q;
  assign rx_if.o_btn_plus_1  = cmd_q.plus_1;
  assign rx_if.o_btn_plus_5  = cmd_q.plus_5;
  assign rx_if.o_btn_minus_1 = cmd_q.minus_1;
  assign rx_if.o_btn_minus_5 = cmd_q.minus_5;
  assign rx_if.o_btn_reset   = cmd_q.reset;

endmodule
